// File: rtl/miriscv_pkg.sv
// Shared core constants and types used by the instruction-fetch path.
package miriscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned PF_DEPTH = 4;

    typedef enum logic {
        PF_IDLE,
        PF_STREAM
    } pf_state_e;

endpackage

// File: rtl/miriscv_sync_fifo.sv
// Small synchronous FIFO with a single-cycle clear; DEPTH must be a power of 2.
module miriscv_sync_fifo #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/miriscv_instr_prefetch_buffer.sv
// Sequential instruction prefetcher between the fetch unit and instruction memory;
// buffers words ahead of the PC and discards stale responses after redirect/flush.
module miriscv_instr_prefetch_buffer
    import miriscv_pkg::*;
#(
    parameter int unsigned DEPTH = PF_DEPTH
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            core_req_i,
    input  logic [XLEN-1:0] core_addr_i,
    output logic            core_rvalid_o,
    output logic [31:0]     core_rdata_o,
    input  logic            flush_i,

    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [31:0]     mem_rdata_i
);

    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam int unsigned CW1 = CW + 1;

    pf_state_e       state_q,       state_d;
    logic [XLEN-1:0] pf_addr_q,     pf_addr_d;
    logic [XLEN-1:0] exp_addr_q,    exp_addr_d;
    logic [CW-1:0]   inflight_q,    inflight_d;
    logic [CW-1:0]   discard_q,     discard_d;
    logic            core_rvalid_q, core_rvalid_d;
    logic [31:0]     core_rdata_q,  core_rdata_d;

    logic [CW-1:0]   count;
    logic [31:0]     head;
    logic [CW1-1:0]  credit_used;
    logic [XLEN-1:0] new_addr;
    logic            addr_match;
    logic            core_ready;
    logic            start, redirect, deliver, kill;
    logic            accept, resp_keep, resp_drop, push;
    logic            unused_addr_lsb;

    assign unused_addr_lsb = ^core_addr_i[1:0];

    assign new_addr    = {core_addr_i[XLEN-1:2], 2'b00};
    assign addr_match  = (core_addr_i[XLEN-1:2] == exp_addr_q[XLEN-1:2]);
    assign core_ready  = core_req_i & ~core_rvalid_q;

    // Every buffered word, kept request and dropped request holds one credit.
    assign credit_used = CW1'(count) + CW1'(inflight_q) + CW1'(discard_q);
    assign mem_req_o   = (state_q == PF_STREAM) & ~flush_i & (credit_used < CW1'(DEPTH));
    assign mem_addr_o  = pf_addr_q;
    assign accept      = mem_req_o & mem_gnt_i;

    assign start    = (state_q == PF_IDLE)   & core_ready & ~flush_i;
    assign redirect = (state_q == PF_STREAM) & core_ready & ~flush_i & ~addr_match;
    assign deliver  = (state_q == PF_STREAM) & core_ready & ~flush_i & addr_match & (count != '0);
    assign kill     = flush_i | redirect;

    assign resp_drop = mem_rvalid_i & (discard_q != '0);
    assign resp_keep = mem_rvalid_i & (discard_q == '0);
    assign push      = resp_keep & ~kill;

    miriscv_sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (deliver),
        .clear_i (kill),
        .data_i  (mem_rdata_i),
        .data_o  (head),
        .count_o (count)
    );

    always_comb begin
        state_d       = state_q;
        pf_addr_d     = pf_addr_q;
        exp_addr_d    = exp_addr_q;
        inflight_d    = inflight_q + CW'(accept) - CW'(resp_keep);
        discard_d     = discard_q - CW'(resp_drop);
        core_rvalid_d = deliver;
        core_rdata_d  = deliver ? head : core_rdata_q;

        if (flush_i) begin
            state_d = PF_IDLE;
        end else if (start) begin
            state_d = PF_STREAM;
        end

        if (accept) begin
            pf_addr_d = pf_addr_q + XLEN'(4);
        end
        if (deliver) begin
            exp_addr_d = exp_addr_q + XLEN'(4);
        end
        if (start || redirect) begin
            pf_addr_d  = new_addr;
            exp_addr_d = new_addr;
        end

        // Kept requests become discards; one landing this cycle is already gone.
        if (kill) begin
            discard_d  = discard_q - CW'(resp_drop) + inflight_q - CW'(resp_keep);
            inflight_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= PF_IDLE;
            pf_addr_q     <= '0;
            exp_addr_q    <= '0;
            inflight_q    <= '0;
            discard_q     <= '0;
            core_rvalid_q <= 1'b0;
            core_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            pf_addr_q     <= pf_addr_d;
            exp_addr_q    <= exp_addr_d;
            inflight_q    <= inflight_d;
            discard_q     <= discard_d;
            core_rvalid_q <= core_rvalid_d;
            core_rdata_q  <= core_rdata_d;
        end
    end

    assign core_rvalid_o = core_rvalid_q;
    assign core_rdata_o  = core_rdata_q;

endmodule

// File: tb/tb_miriscv_instr_prefetch_buffer.sv
// Directed bench for the prefetch buffer with an in-order, fixed-latency memory model.
module tb_miriscv_instr_prefetch_buffer;
    import miriscv_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            core_req_i;
    logic [XLEN-1:0] core_addr_i;
    logic            core_rvalid_o;
    logic [31:0]     core_rdata_o;
    logic            flush_i;
    logic            mem_req_o;
    logic [XLEN-1:0] mem_addr_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i = 1'b0;
    logic [31:0]     mem_rdata_i  = '0;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int mem_lat     = 1;

    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] acc_addr[$];
    int          acc_cyc[$];

    always #5 clk_i = ~clk_i;

    miriscv_instr_prefetch_buffer #(.DEPTH(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .core_req_i    (core_req_i),
        .core_addr_i   (core_addr_i),
        .core_rvalid_o (core_rvalid_o),
        .core_rdata_o  (core_rdata_o),
        .flush_i       (flush_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // Memory: accept at the edge ending cycle k, respond during cycle k + mem_lat.
    always @(posedge clk_i) begin
        if (rst_i) begin
            pend_addr.delete();
            pend_due.delete();
            acc_addr.delete();
            acc_cyc.delete();
            mem_rvalid_i <= 1'b0;
            mem_rdata_i  <= '0;
        end else begin
            if (mem_req_o && mem_gnt_i) begin
                pend_addr.push_back(mem_addr_o);
                pend_due.push_back(cyc + mem_lat);
                acc_addr.push_back(mem_addr_o);
                acc_cyc.push_back(cyc);
            end
            if (pend_due.size() > 0 && pend_due[0] == cyc + 1) begin
                mem_rvalid_i <= 1'b1;
                mem_rdata_i  <= mem_word(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                mem_rvalid_i <= 1'b0;
            end
        end
        cyc = cyc + 1;
    end

    task automatic do_reset();
        @(negedge clk_i);
        rst_i       = 1'b1;
        core_req_i  = 1'b0;
        core_addr_i = '0;
        flush_i     = 1'b0;
        mem_gnt_i   = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Raises the request at the next falling edge and counts rising edges until rvalid.
    task automatic fetch(input logic [31:0] a, output logic [31:0] d, output int lat);
        @(negedge clk_i);
        core_req_i  = 1'b1;
        core_addr_i = a;
        lat         = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            lat++;
            if (core_rvalid_o) break;
        end
        vectors++;
        if (core_rvalid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL fetch_timeout addr=%h rvalid=%b expected=1", a, core_rvalid_o);
        end
        d          = core_rdata_o;
        core_req_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk_i);
        vectors++;
        if ({core_rvalid_o, core_rdata_o, mem_req_o, mem_addr_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs rvalid=%b rdata=%h req=%b addr=%h expected all zero",
                     core_rvalid_o, core_rdata_o, mem_req_o, mem_addr_o);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] d;
        int lat;
        logic [31:0] addrs [4] = '{32'h80, 32'h84, 32'h8B, 32'h8C};
        logic [31:0] words [4] = '{32'h80, 32'h84, 32'h88, 32'h8C};
        int lats [4] = '{4, 1, 1, 1};
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 4; i++) begin
            fetch(addrs[i], d, lat);
            vectors++;
            if (d !== mem_word(words[i]) || lat != lats[i]) begin
                miscompares++;
                $display("FAIL seq_fetch[%0d] data=%h lat=%0d expected data=%h lat=%0d",
                         i, d, lat, mem_word(words[i]), lats[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (acc_addr.size() <= i || acc_addr[i] !== 32'h80 + 32'(4 * i) ||
                acc_cyc[i] != acc_cyc[0] + i) begin
                miscompares++;
                $display("FAIL seq_mem_addr[%0d] logged=%0d accepts expected addr=%h back-to-back",
                         i, acc_addr.size(), 32'h80 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_buffer_full();
        logic [31:0] d;
        int lat;
        do_reset();
        mem_lat = 3;
        fetch(32'h100, d, lat);
        vectors++;
        if (d !== mem_word(32'h100) || lat != 6) begin
            miscompares++;
            $display("FAIL full_first data=%h lat=%0d expected data=%h lat=6", d, lat, mem_word(32'h100));
        end
        repeat (12) @(negedge clk_i);
        vectors++;
        if (acc_addr.size() != 5 || mem_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL full_credit accepts=%0d req=%b expected accepts=5 req=0", acc_addr.size(), mem_req_o);
        end
        fetch(32'h104, d, lat);
        vectors++;
        if (d !== mem_word(32'h104) || lat != 1) begin
            miscompares++;
            $display("FAIL full_hit data=%h lat=%0d expected data=%h lat=1", d, lat, mem_word(32'h104));
        end
        vectors++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h114) begin
            miscompares++;
            $display("FAIL full_refill req=%b addr=%h expected req=1 addr=00000114", mem_req_o, mem_addr_o);
        end
    endtask

    task automatic test_redirect();
        logic [31:0] d;
        int lat;
        do_reset();
        mem_lat = 3;
        fetch(32'h10C, d, lat);
        vectors++;
        if (d !== mem_word(32'h10C) || lat != 6) begin
            miscompares++;
            $display("FAIL redir_pre data=%h lat=%0d expected data=%h lat=6", d, lat, mem_word(32'h10C));
        end
        // exp_addr is now 0x110 with 0x118/0x11C outstanding and 0x118 landing this cycle.
        @(negedge clk_i);
        core_req_i  = 1'b1;
        core_addr_i = 32'h200;
        @(negedge clk_i);
        vectors++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200 || core_rvalid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_resume req=%b addr=%h rvalid=%b expected req=1 addr=00000200 rvalid=0",
                     mem_req_o, mem_addr_o, core_rvalid_o);
        end
        for (int i = 0; i < 40 && !core_rvalid_o; i++) @(negedge clk_i);
        vectors++;
        if (core_rvalid_o !== 1'b1 || core_rdata_o !== mem_word(32'h200)) begin
            miscompares++;
            $display("FAIL redir_first rvalid=%b data=%h expected rvalid=1 data=%h",
                     core_rvalid_o, core_rdata_o, mem_word(32'h200));
        end
        core_req_i = 1'b0;
        fetch(32'h204, d, lat);
        vectors++;
        if (d !== mem_word(32'h204) || lat != 1) begin
            miscompares++;
            $display("FAIL redir_next data=%h lat=%0d expected data=%h lat=1", d, lat, mem_word(32'h204));
        end
        fetch(32'h208, d, lat);
        vectors++;
        if (d !== mem_word(32'h208)) begin
            miscompares++;
            $display("FAIL redir_third data=%h expected %h", d, mem_word(32'h208));
        end
    endtask

    task automatic test_flush();
        logic [31:0] d;
        int lat;
        do_reset();
        mem_lat = 1;
        fetch(32'h300, d, lat);
        vectors++;
        if (d !== mem_word(32'h300)) begin
            miscompares++;
            $display("FAIL flush_pre data=%h expected %h", d, mem_word(32'h300));
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (mem_rvalid_i) break;
        end
        vectors++;
        if (mem_rvalid_i !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_wait_rvalid mem_rvalid=%b expected 1", mem_rvalid_i);
        end
        // 0x304 is buffered, so without the flush this request would be served.
        flush_i     = 1'b1;
        core_req_i  = 1'b1;
        core_addr_i = 32'h304;
        #1;
        vectors++;
        if (mem_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_gate req=%b expected 0", mem_req_o);
        end
        @(negedge clk_i);
        flush_i    = 1'b0;
        core_req_i = 1'b0;
        vectors++;
        if (core_rvalid_o !== 1'b0 || mem_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_after rvalid=%b req=%b expected rvalid=0 req=0", core_rvalid_o, mem_req_o);
        end
        @(negedge clk_i);
        vectors++;
        if (mem_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle req=%b expected 0", mem_req_o);
        end
        fetch(32'h400, d, lat);
        vectors++;
        if (d !== mem_word(32'h400)) begin
            miscompares++;
            $display("FAIL flush_restart data=%h expected %h", d, mem_word(32'h400));
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        int lat;
        logic [31:0] addrs [3] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        int lats [3] = '{4, 1, 1};
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 3; i++) begin
            fetch(addrs[i], d, lat);
            vectors++;
            if (d !== mem_word(addrs[i]) || lat != lats[i]) begin
                miscompares++;
                $display("FAIL wrap_fetch[%0d] data=%h lat=%0d expected data=%h lat=%0d",
                         i, d, lat, mem_word(addrs[i]), lats[i]);
            end
        end
        vectors++;
        if (acc_addr.size() < 2 || acc_addr[1] !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_pf_addr accepts=%0d expected second prefetch 00000000", acc_addr.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int lat;
        do_reset();
        mem_lat = 1;
        fetch(32'h500, d, lat);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        vectors++;
        if ({core_rvalid_o, core_rdata_o, mem_req_o, mem_addr_o} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs rvalid=%b rdata=%h req=%b addr=%h expected all zero",
                     core_rvalid_o, core_rdata_o, mem_req_o, mem_addr_o);
        end
        rst_i = 1'b0;
        fetch(32'h40, d, lat);
        vectors++;
        if (d !== mem_word(32'h40) || lat != 4) begin
            miscompares++;
            $display("FAIL midreset_fetch data=%h lat=%0d expected data=%h lat=4", d, lat, mem_word(32'h40));
        end
        vectors++;
        if (acc_addr.size() < 1 || acc_addr[0] !== 32'h40) begin
            miscompares++;
            $display("FAIL midreset_first_req accepts=%0d expected first address 00000040", acc_addr.size());
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        core_req_i  = 1'b0;
        core_addr_i = '0;
        flush_i     = 1'b0;
        mem_gnt_i   = 1'b1;
        test_reset();
        test_sequential();
        test_buffer_full();
        test_redirect();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
